// File: rtl/atm_pkg.sv
// Shared types and widths for the ATM login front-end.
package atm_pkg;

   localparam int unsigned ACC_W      = 12;
   localparam int unsigned PIN_W      = 4;
   localparam int unsigned IDX_W      = 4;
   localparam int unsigned ACC_DIGITS = 4;
   localparam int unsigned BCD_W      = 4;
   localparam int unsigned ACC_SUM_W  = 14;
   localparam int unsigned FAIL_W     = 3;

   localparam logic ACTION_FIND = 1'b0;
   localparam logic ACTION_AUTH = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ACC_ENTRY,
      ST_FIND_WAIT,
      ST_PIN_ENTRY,
      ST_AUTH_WAIT,
      ST_SESSION,
      ST_LOCKED
   } login_state_t;

   function automatic logic is_dec_digit(input logic [BCD_W-1:0] d);
      return d <= BCD_W'(9);
   endfunction

endpackage

// File: rtl/bcd_acc_entry.sv
// Decimal account-number accumulator: load/append digits, counts them,
// flags when all digits are present and when the value exceeds the account range.
module bcd_acc_entry
   import atm_pkg::*;
(
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clear_i,
   input  logic             load_i,
   input  logic             add_i,
   input  logic [BCD_W-1:0] digit_i,
   output logic [ACC_W-1:0] acc_o,
   output logic             full_o,
   output logic             overflow_o
);

   localparam int unsigned          CNT_W     = $clog2(ACC_DIGITS + 1);
   localparam logic [ACC_SUM_W-1:0] ACC_LIMIT = ACC_SUM_W'((1 << ACC_W) - 1);

   logic [ACC_SUM_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 full_q, full_d;
   logic                 ovf_q, ovf_d;

   // Digits beyond the account length are dropped once full.
   always_comb begin
      acc_d = acc_q;
      cnt_d = cnt_q;
      if (clear_i) begin
         acc_d = '0;
         cnt_d = '0;
      end else if (load_i) begin
         acc_d = ACC_SUM_W'(digit_i);
         cnt_d = CNT_W'(1);
      end else if (add_i && !full_q) begin
         acc_d = ACC_SUM_W'(acc_q * ACC_SUM_W'(10)) + ACC_SUM_W'(digit_i);
         cnt_d = cnt_q + CNT_W'(1);
      end
      full_d = (cnt_d == CNT_W'(ACC_DIGITS));
      ovf_d  = (acc_d > ACC_LIMIT);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         acc_q  <= '0;
         cnt_q  <= '0;
         full_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         acc_q  <= acc_d;
         cnt_q  <= cnt_d;
         full_q <= full_d;
         ovf_q  <= ovf_d;
      end
   end

   assign acc_o      = acc_q[ACC_W-1:0];
   assign full_o     = full_q;
   assign overflow_o = ovf_q;

endmodule

// File: rtl/atm_login_sequencer.sv
// Keypad-to-authenticator login sequencer with retry limiting and lockout.
// Optional inactivity logout is enabled by defining ATM_LOGIN_TIMEOUT_EN.
module atm_login_sequencer
   import atm_pkg::*;
#(
   parameter int unsigned MAX_TRIES      = 3,
   parameter int unsigned LOCK_CYCLES    = 1024,
   parameter int unsigned RESP_LAT       = 1,
   parameter int unsigned TIMEOUT_CYCLES = 4096
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              digit_valid_i,
   input  logic [BCD_W-1:0]  digit_i,
   input  logic              enter_i,
   input  logic              cancel_i,
   output logic [ACC_W-1:0]  acc_number_o,
   output logic [PIN_W-1:0]  pin_o,
   output logic              action_o,
   output logic              deauth_o,
   input  logic              was_successful_i,
   input  logic [IDX_W-1:0]  acc_index_i,
   output logic              session_active_o,
   output logic [IDX_W-1:0]  session_index_o,
   output logic [FAIL_W-1:0] fail_count_o,
   output logic              locked_o,
   output logic              err_o
);

   localparam int unsigned WAIT_W = (RESP_LAT > 1) ? $clog2(RESP_LAT) : 1;
   localparam int unsigned LOCK_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

   login_state_t      state_q, state_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic [LOCK_W-1:0] lock_q, lock_d;
   logic [IDX_W-1:0]  cand_q, cand_d, sidx_q, sidx_d;
   logic [PIN_W-1:0]  pin_reg_q, pin_reg_d, pin_q, pin_d;
   logic              pin_valid_q, pin_valid_d;
   logic [FAIL_W-1:0] fail_q, fail_d;
   logic [ACC_W-1:0]  acc_num_q, acc_num_d;
   logic              action_q, action_d, deauth_q, deauth_d;
   logic              active_q, active_d, locked_q, locked_d, err_q, err_d;

   logic              acc_clear_c, acc_load_c, acc_add_c;
   logic [ACC_W-1:0]  acc_val_c;
   logic              acc_full_c, acc_ovf_c;
   logic              timeout_c, cancel_c, enter_c, digit_c;
   logic              wait_done_c, lock_done_c;
   logic [FAIL_W-1:0] fail_inc_c;

   bcd_acc_entry u_acc (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .clear_i    (acc_clear_c),
      .load_i     (acc_load_c),
      .add_i      (acc_add_c),
      .digit_i    (digit_i),
      .acc_o      (acc_val_c),
      .full_o     (acc_full_c),
      .overflow_o (acc_ovf_c)
   );

   // Strobe priority: cancel (or inactivity timeout) > enter > digit.
   assign cancel_c    = cancel_i | timeout_c;
   assign enter_c     = enter_i & ~cancel_c;
   assign digit_c     = digit_valid_i & is_dec_digit(digit_i) & ~enter_i & ~cancel_c;
   assign wait_done_c = (wait_q == WAIT_W'(RESP_LAT - 1));
   assign lock_done_c = (lock_q == LOCK_W'(LOCK_CYCLES - 1));
   assign fail_inc_c  = fail_q + FAIL_W'(1);

   always_comb begin
      state_d     = state_q;
      wait_d      = wait_q;
      lock_d      = lock_q;
      cand_d      = cand_q;
      sidx_d      = sidx_q;
      pin_reg_d   = pin_reg_q;
      pin_valid_d = pin_valid_q;
      fail_d      = fail_q;
      acc_num_d   = acc_num_q;
      pin_d       = pin_q;
      action_d    = action_q;
      deauth_d    = 1'b0;
      err_d       = 1'b0;
      acc_clear_c = 1'b0;
      acc_load_c  = 1'b0;
      acc_add_c   = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (digit_c) begin
               acc_load_c = 1'b1;
               state_d    = ST_ACC_ENTRY;
            end
         end
         ST_ACC_ENTRY: begin
            if (cancel_c) begin
               acc_clear_c = 1'b1;
               state_d     = ST_IDLE;
            end else if (enter_c) begin
               acc_clear_c = 1'b1;
               if (acc_full_c && !acc_ovf_c) begin
                  acc_num_d = acc_val_c;
                  action_d  = ACTION_FIND;
                  wait_d    = '0;
                  state_d   = ST_FIND_WAIT;
               end else begin
                  err_d   = 1'b1;
                  state_d = ST_IDLE;
               end
            end else if (digit_c) begin
               acc_add_c = 1'b1;
            end
         end
         ST_FIND_WAIT: begin
            if (wait_done_c) begin
               wait_d = '0;
               if (was_successful_i) begin
                  cand_d      = acc_index_i;
                  pin_reg_d   = '0;
                  pin_valid_d = 1'b0;
                  state_d     = ST_PIN_ENTRY;
               end else begin
                  err_d   = 1'b1;
                  state_d = ST_IDLE;
               end
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end
         ST_PIN_ENTRY: begin
            if (cancel_c) begin
               fail_d      = '0;
               pin_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end else if (enter_c) begin
               if (pin_valid_q) begin
                  pin_d    = pin_reg_q;
                  action_d = ACTION_AUTH;
                  wait_d   = '0;
                  state_d  = ST_AUTH_WAIT;
               end else begin
                  err_d = 1'b1;
               end
            end else if (digit_c) begin
               pin_reg_d   = digit_i;
               pin_valid_d = 1'b1;
            end
         end
         ST_AUTH_WAIT: begin
            if (wait_done_c) begin
               wait_d = '0;
               if (was_successful_i) begin
                  sidx_d  = cand_q;
                  fail_d  = '0;
                  state_d = ST_SESSION;
               end else begin
                  fail_d = fail_inc_c;
                  err_d  = 1'b1;
                  if (fail_inc_c == FAIL_W'(MAX_TRIES)) begin
                     lock_d  = '0;
                     state_d = ST_LOCKED;
                  end else begin
                     pin_reg_d   = '0;
                     pin_valid_d = 1'b0;
                     state_d     = ST_PIN_ENTRY;
                  end
               end
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end
         ST_SESSION: begin
            if (cancel_c) begin
               deauth_d = 1'b1;
               state_d  = ST_IDLE;
            end
         end
         ST_LOCKED: begin
            if (lock_done_c) begin
               lock_d  = '0;
               fail_d  = '0;
               state_d = ST_IDLE;
            end else begin
               lock_d = lock_q + LOCK_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase

      active_d = (state_d == ST_SESSION);
      locked_d = (state_d == ST_LOCKED);
   end

`ifdef ATM_LOGIN_TIMEOUT_EN
   localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [TO_W-1:0] idle_cnt_q, idle_cnt_d;
   logic            idle_state_c, any_strobe_c;

   assign idle_state_c = (state_q == ST_ACC_ENTRY) || (state_q == ST_PIN_ENTRY) ||
                         (state_q == ST_SESSION);
   assign any_strobe_c = digit_valid_i | enter_i | cancel_i;
   assign timeout_c    = idle_state_c && (idle_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

   // Counts quiet cycles; restarts on any keypad activity or state change.
   always_comb begin
      idle_cnt_d = idle_cnt_q + TO_W'(1);
      if (!idle_state_c || any_strobe_c || (state_d != state_q)) begin
         idle_cnt_d = '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) idle_cnt_q <= '0;
      else       idle_cnt_q <= idle_cnt_d;
   end
`else
   logic unused_timeout_c;
   assign timeout_c        = 1'b0;
   assign unused_timeout_c = (TIMEOUT_CYCLES == 0);
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= ST_IDLE;
         wait_q      <= '0;
         lock_q      <= '0;
         cand_q      <= '0;
         sidx_q      <= '0;
         pin_reg_q   <= '0;
         pin_valid_q <= 1'b0;
         fail_q      <= '0;
         acc_num_q   <= '0;
         pin_q       <= '0;
         action_q    <= ACTION_FIND;
         deauth_q    <= 1'b0;
         active_q    <= 1'b0;
         locked_q    <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         wait_q      <= wait_d;
         lock_q      <= lock_d;
         cand_q      <= cand_d;
         sidx_q      <= sidx_d;
         pin_reg_q   <= pin_reg_d;
         pin_valid_q <= pin_valid_d;
         fail_q      <= fail_d;
         acc_num_q   <= acc_num_d;
         pin_q       <= pin_d;
         action_q    <= action_d;
         deauth_q    <= deauth_d;
         active_q    <= active_d;
         locked_q    <= locked_d;
         err_q       <= err_d;
      end
   end

   assign acc_number_o     = acc_num_q;
   assign pin_o            = pin_q;
   assign action_o         = action_q;
   assign deauth_o         = deauth_q;
   assign session_active_o = active_q;
   assign session_index_o  = sidx_q;
   assign fail_count_o     = fail_q;
   assign locked_o         = locked_q;
   assign err_o            = err_q;

endmodule

// File: tb/tb_atm_login_sequencer.sv
// Bench for atm_login_sequencer: directed keypad scenarios, a spec-level model
// compared every cycle, and literal expectations at key points.
module tb_atm_login_sequencer;

   localparam int unsigned MAX_TRIES      = 3;
   localparam int unsigned LOCK_CYCLES    = 1024;
   localparam int unsigned RESP_LAT       = 1;
   localparam int unsigned TIMEOUT_CYCLES = 4096;

   // Authenticator account table: number, PIN; index is the position.
   localparam int ACCTS[3] = '{2749, 2175, 2910};
   localparam int PINS[3]  = '{0, 8, 7};

   localparam int PH_IDLE = 0, PH_ACC = 1, PH_FIND = 2, PH_PIN = 3,
                  PH_AUTH = 4, PH_SESS = 5, PH_LOCK = 6;

   logic        clk = 1'b0;
   logic        rst;
   logic        digit_valid, enter, cancel;
   logic [3:0]  digit;
   logic [11:0] acc_number;
   logic [3:0]  pin;
   logic        action, deauth;
   logic        was_successful;
   logic [3:0]  acc_index;
   logic        session_active;
   logic [3:0]  session_index;
   logic [2:0]  fail_count;
   logic        locked, err;

   int checks   = 0;
   int failures = 0;
   int err_seen = 0;

   atm_login_sequencer #(
      .MAX_TRIES      (MAX_TRIES),
      .LOCK_CYCLES    (LOCK_CYCLES),
      .RESP_LAT       (RESP_LAT),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) dut (
      .clk_i            (clk),
      .rst_i            (rst),
      .digit_valid_i    (digit_valid),
      .digit_i          (digit),
      .enter_i          (enter),
      .cancel_i         (cancel),
      .acc_number_o     (acc_number),
      .pin_o            (pin),
      .action_o         (action),
      .deauth_o         (deauth),
      .was_successful_i (was_successful),
      .acc_index_i      (acc_index),
      .session_active_o (session_active),
      .session_index_o  (session_index),
      .fail_count_o     (fail_count),
      .locked_o         (locked),
      .err_o            (err)
   );

   always #5 clk = ~clk;

   // Combinational authenticator: FIND matches the account, AUTHENTICATE also the PIN.
   function automatic logic [4:0] auth_resp(input logic [11:0] a, input logic [3:0] p,
                                            input logic act);
      logic [4:0] r;
      r = 5'b0;
      for (int i = 0; i < 3; i++) begin
         if (int'(a) == ACCTS[i] && (act == 1'b0 || int'(p) == PINS[i])) r = {1'b1, 4'(i)};
      end
      return r;
   endfunction

   assign {was_successful, acc_index} = auth_resp(acc_number, pin, action);

   // ---------------- behavioural model ----------------
   logic [11:0] e_acc;
   logic [3:0]  e_pin, e_sidx;
   logic        e_action, e_deauth, e_active, e_locked, e_err;
   logic [2:0]  e_fail;
   int          ph, ph_prev, timer, idle, pin_key, val;
   logic [3:0]  cand;
   int          digits[$];
   logic [4:0]  m_resp;
   bit          m_c, m_en, m_d, m_ready = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         e_acc = '0; e_pin = '0; e_action = 1'b0; e_deauth = 1'b0; e_active = 1'b0;
         e_sidx = '0; e_fail = '0; e_locked = 1'b0; e_err = 1'b0;
         ph = PH_IDLE; timer = 0; idle = 0; pin_key = -1; cand = '0;
         digits.delete();
         m_ready = 1'b1;
      end else begin
         e_err = 1'b0; e_deauth = 1'b0; ph_prev = ph;
         m_c = cancel;
`ifdef ATM_LOGIN_TIMEOUT_EN
         if (ph == PH_ACC || ph == PH_PIN || ph == PH_SESS) begin
            if (digit_valid || enter || cancel) idle = 0;
            else if (idle == int'(TIMEOUT_CYCLES) - 1) m_c = 1'b1;
            else idle++;
         end
`endif
         m_en = enter && !m_c;
         m_d  = digit_valid && (digit <= 4'd9) && !enter && !m_c;
         case (ph)
            PH_IDLE: if (m_d) begin digits.delete(); digits.push_back(int'(digit)); ph = PH_ACC; end
            PH_ACC: begin
               if (m_c) ph = PH_IDLE;
               else if (m_en) begin
                  val = 0;
                  foreach (digits[i]) val = val * 10 + digits[i];
                  if (digits.size() == 4 && val <= 4095) begin
                     e_acc = 12'(val); e_action = 1'b0; timer = int'(RESP_LAT); ph = PH_FIND;
                  end else begin
                     e_err = 1'b1; ph = PH_IDLE;
                  end
               end else if (m_d && digits.size() < 4) digits.push_back(int'(digit));
            end
            PH_FIND: begin
               timer--;
               if (timer == 0) begin
                  m_resp = auth_resp(e_acc, e_pin, e_action);
                  if (m_resp[4]) begin cand = m_resp[3:0]; pin_key = -1; ph = PH_PIN; end
                  else begin e_err = 1'b1; ph = PH_IDLE; end
               end
            end
            PH_PIN: begin
               if (m_c) begin e_fail = '0; ph = PH_IDLE; end
               else if (m_en) begin
                  if (pin_key < 0) e_err = 1'b1;
                  else begin e_pin = 4'(pin_key); e_action = 1'b1; timer = int'(RESP_LAT); ph = PH_AUTH; end
               end else if (m_d) pin_key = int'(digit);
            end
            PH_AUTH: begin
               timer--;
               if (timer == 0) begin
                  m_resp = auth_resp(e_acc, e_pin, e_action);
                  if (m_resp[4]) begin e_sidx = cand; e_fail = '0; ph = PH_SESS; end
                  else begin
                     e_fail = e_fail + 3'd1; e_err = 1'b1;
                     if (e_fail == 3'(MAX_TRIES)) begin timer = int'(LOCK_CYCLES); ph = PH_LOCK; end
                     else begin pin_key = -1; ph = PH_PIN; end
                  end
               end
            end
            PH_SESS: if (m_c) begin e_deauth = 1'b1; ph = PH_IDLE; end
            PH_LOCK: begin
               timer--;
               if (timer == 0) begin e_fail = '0; ph = PH_IDLE; end
            end
            default: ph = PH_IDLE;
         endcase
         if (ph != ph_prev) idle = 0;
         e_active = (ph == PH_SESS);
         e_locked = (ph == PH_LOCK);
      end
   end

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      if (m_ready) begin
         checks++;
         if ({acc_number, pin, action, deauth, session_active, session_index, fail_count, locked, err} !==
             {e_acc, e_pin, e_action, e_deauth, e_active, e_sidx, e_fail, e_locked, e_err}) begin
            failures++;
            $display("FAIL cycle_cmp t=%0t dut acc=%0d pin=%0d act=%b deauth=%b active=%b sidx=%0d fail=%0d locked=%b err=%b | model acc=%0d pin=%0d act=%b deauth=%b active=%b sidx=%0d fail=%0d locked=%b err=%b",
                     $time, acc_number, pin, action, deauth, session_active, session_index, fail_count, locked, err,
                     e_acc, e_pin, e_action, e_deauth, e_active, e_sidx, e_fail, e_locked, e_err);
         end
      end
      if (err === 1'b1) err_seen++;
   end

   // ---------------- stimulus helpers ----------------
   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s got=%0d want=%0d", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic key(input int d);
      digit = 4'(d); digit_valid = 1'b1; tick(1); digit_valid = 1'b0;
   endtask

   task automatic press_enter();
      enter = 1'b1; tick(1); enter = 1'b0;
   endtask

   task automatic press_cancel();
      cancel = 1'b1; tick(1); cancel = 1'b0;
   endtask

   task automatic type_account(input int a);
      key(a / 1000); key((a / 100) % 10); key((a / 10) % 10); key(a % 10);
   endtask

   task automatic find_account(input int a);
      type_account(a); press_enter(); tick(int'(RESP_LAT));
   endtask

   task automatic three_bad_pins();
      for (int k = 1; k <= 3; k++) begin
         key(5); press_enter(); tick(int'(RESP_LAT));
         check("lock_fail_count", int'(fail_count), k);
         check("lock_err_pulse", int'(err), 1);
         check("lock_locked", int'(locked), (k == 3) ? 1 : 0);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, err_base;
      rst = 1'b1; digit_valid = 1'b0; digit = '0; enter = 1'b0; cancel = 1'b0;
      tick(2);
      rst = 1'b0;
      check("rst_acc_number", int'(acc_number), 0);
      check("rst_action", int'(action), 0);
      check("rst_session_active", int'(session_active), 0);
      check("rst_fail_count", int'(fail_count), 0);
      check("rst_locked_err", int'({locked, err, deauth}), 0);

      // Good login 2749 / PIN 0.
      err_base = err_seen;
      type_account(2749); press_enter();
      check("t1_acc_number", int'(acc_number), 2749);
      check("t1_action_find", int'(action), 0);
      tick(int'(RESP_LAT));
      key(0); press_enter();
      check("t1_active_early", int'(session_active), 0);
      check("t1_action_auth", int'(action), 1);
      tick(int'(RESP_LAT));
      check("t1_session_active", int'(session_active), 1);
      check("t1_session_index", int'(session_index), 0);
      check("t1_fail_count", int'(fail_count), 0);
      check("t1_no_err", err_seen - err_base, 0);
      press_cancel();
      check("t1_deauth", int'(deauth), 1);
      check("t1_active_fall", int'(session_active), 0);
      tick(1);
      check("t1_deauth_width", int'(deauth), 0);

      // Out-of-range account 9999: rejected, authenticator inputs untouched.
      type_account(9999); press_enter();
      check("t4_err", int'(err), 1);
      check("t4_acc_kept", int'(acc_number), 2749);
      check("t4_action_kept", int'(action), 1);
      tick(1);
      check("t4_err_width", int'(err), 0);

      // Unknown account 1234: FIND fails.
      err_base = err_seen;
      type_account(1234); press_enter();
      check("t2_acc_number", int'(acc_number), 1234);
      check("t2_action", int'(action), 0);
      tick(int'(RESP_LAT));
      check("t2_err", int'(err), 1);
      tick(1);
      check("t2_err_count", err_seen - err_base, 1);

      // Lockout on 2175 with wrong PIN 5.
      find_account(2175);
      three_bad_pins();
      n = 0;
      while (locked === 1'b1 && n < 2000) begin n++; tick(1); end
      check("t3_lock_cycles", n, int'(LOCK_CYCLES));
      check("t3_fail_cleared", int'(fail_count), 0);

      // Session 2910 / 7 then logout.
      find_account(2910); key(7); press_enter(); tick(int'(RESP_LAT));
      check("t5_session_index", int'(session_index), 2);
      check("t5_active", int'(session_active), 1);
      press_cancel();
      check("t5_deauth_and_fall", int'({deauth, session_active}), 2);

      // Reset during AUTH_WAIT.
      find_account(2910); key(7); press_enter();
      check("t6_pin_driven", int'(pin), 7);
      rst = 1'b1; tick(1); rst = 1'b0;
      check("t6_rst_pin", int'(pin), 0);
      check("t6_rst_acc", int'(acc_number), 0);
      check("t6_rst_action", int'(action), 0);

      // Reset during SESSION: no deauth pulse.
      find_account(2910); key(7); press_enter(); tick(int'(RESP_LAT));
      rst = 1'b1; tick(1); rst = 1'b0;
      check("t6_rst_sess", int'({deauth, session_active, session_index}), 0);

      // Reset during LOCKED.
      find_account(2175);
      three_bad_pins();
      tick(100);
      check("t6_still_locked", int'(locked), 1);
      rst = 1'b1; tick(1); rst = 1'b0;
      check("t6_rst_locked", int'({locked, fail_count}), 0);

`ifdef ATM_LOGIN_TIMEOUT_EN
      find_account(2749); key(0); press_enter(); tick(int'(RESP_LAT));
      n = 0;
      while (deauth !== 1'b1 && n < 5000) begin n++; tick(1); end
      check("to_session_cycles", n, int'(TIMEOUT_CYCLES));
      check("to_active_fall", int'(session_active), 0);
`endif

      tick(3);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
